// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: types, widths and the round-robin pick helper shared by the
// register-bank arbiter.
//   arb_state_e : arbiter FSM states
//   REG_ADDR_W / REG_DATA_W : register bus widths, shared with register_bank and cmd_dispatcher
//   rr_pick()   : first set request bit at or above the pointer, wrapping at num_req
package reg_arb_pkg;

   localparam int unsigned REG_ADDR_W = 8;
   localparam int unsigned REG_DATA_W = 8;
   localparam int unsigned MAX_REQ    = 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // ptr must be below num_req, so a single subtraction handles the wrap.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                        input logic [2:0]         ptr,
                                        input int unsigned        num_req);
      rr_pick_t    res;
      int unsigned j;
      res = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         j = 32'(ptr) + i;
         if (j >= num_req) j = j - num_req;
         if (i < num_req && !res.found && req[j[2:0]]) begin
            res.found = 1'b1;
            res.idx   = j[2:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational NUM_REQ-wide round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index this round
//   found : at least one request set
//   idx   : winning index (valid when found)
module rr_priority_pick
   import reg_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         ptr,
   output logic               found,
   output logic [2:0]         idx
);

   rr_pick_t pick;

   always_comb begin
      pick  = rr_pick(MAX_REQ'(req), ptr, NUM_REQ);
      found = pick.found;
      idx   = pick.idx;
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbiter giving NUM_REQ requesters serialised
// access to the single-port register_bank (port 0: cmd_dispatcher UART path,
// ports 1+: on-chip status/debug agents).
//   clk, rst            : clock; asynchronous active-low reset
//   req_valid/write     : per-requester request and direction (1=write)
//   req_addr/req_wdata  : packed per-requester fields, slot k at [k*W +: W]
//   req_ready           : one-hot, one-cycle accept pulse
//   rsp_valid/rsp_rdata : one-hot, one-cycle read response; rdata held until next response
//   mem_*               : register_bank strobes/address/data; all zero outside ISSUE
//   busy                : FSM not in IDLE
module reg_bank_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned ADDR_W       = REG_ADDR_W,
   parameter int unsigned DATA_W       = REG_DATA_W,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_write_en,
   output logic [DATA_W-1:0]         mem_write_data,
   output logic                      mem_read_en,
   input  logic [DATA_W-1:0]         mem_read_data,
   output logic                      busy
);

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   arb_state_e        state;
   logic [2:0]        rr_ptr;
   logic [2:0]        owner;
   logic              cap_write;
   logic [1:0]        wait_cnt;

   logic              pick_found;
   logic [2:0]        pick_idx;
   logic [2:0]        next_ptr;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == 3'(i)) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
      next_ptr = (32'(pick_idx) + 32'd1 >= NUM_REQ) ? 3'd0 : pick_idx + 3'd1;
   end

   // Bank strobes and req_ready are loaded on the IDLE->ISSUE edge so they are
   // registered and visible exactly during the ISSUE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         owner          <= '0;
         cap_write      <= 1'b0;
         wait_cnt       <= '0;
         req_ready      <= '0;
         rsp_valid      <= '0;
         rsp_rdata      <= '0;
         mem_addr       <= '0;
         mem_write_en   <= 1'b0;
         mem_write_data <= '0;
         mem_read_en    <= 1'b0;
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  owner          <= pick_idx;
                  cap_write      <= sel_write;
                  rr_ptr         <= next_ptr;
                  mem_addr       <= sel_addr;
                  mem_write_data <= sel_wdata;
                  mem_write_en   <= sel_write;
                  mem_read_en    <= ~sel_write;
                  req_ready      <= ONE << pick_idx;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               mem_addr       <= '0;
               mem_write_data <= '0;
               mem_write_en   <= 1'b0;
               mem_read_en    <= 1'b0;
               wait_cnt       <= 2'(READ_LATENCY - 1);
               state          <= cap_write ? IDLE : WAIT;
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  rsp_rdata <= mem_read_data;
                  rsp_valid <= ONE << owner;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
